sdm_dac_mc: RTL and testbench

- Multi-channel sigma-delta audio DAC with a runtime-selectable 1st/2nd-order modulator.
- Accepts offset-binary PCM frames over a valid/ready interface and buffers one frame.
- Each channel produces a 1-bit pulse-density output at the clk rate; a new frame is loaded every 2^OSR_LOG2 cycles.
- Sits between the audio sample source and the output pads/RC filters.

---
 rtl/sdm_pkg.sv | 25 ++
 rtl/sdm_channel.sv | 94 +++++++++
 rtl/sdm_dac_mc.sv | 107 ++++++++++
 tb/tb_sdm_dac_mc.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdm_pkg.sv
// sdm_pkg: shared definitions for the multi-channel sigma-delta DAC.
//   order_e      modulator order encoding (ORDER_1 / ORDER_2)
//   int_width    width of the 2nd-order integrators for a given sample width
//   midscale     offset-binary midscale, also the feedback magnitude
//   clamp_bound  magnitude limit applied to the 2nd-order input for stability
package sdm_pkg;

    typedef enum logic {
        ORDER_1 = 1'b0,
        ORDER_2 = 1'b1
    } order_e;

    function automatic int int_width(input int width);
        return width + 3;
    endfunction

    function automatic int midscale(input int width);
        return 1 << (width - 1);
    endfunction

    function automatic int clamp_bound(input int width);
        return 1 << (width - 2);
    endfunction

endpackage

// File: rtl/sdm_channel.sv
// sdm_channel: one sigma-delta modulator, 1st or 2nd order.
//   clk, rst_n  clock and asynchronous active-low reset
//   i_en        enable; when low all state is held at zero
//   i_clr       synchronous clear of integrators and output
//   i_order     active modulator order
//   i_cur       current offset-binary sample
//   o_dout      registered 1-bit pulse-density output
module sdm_channel
    import sdm_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  order_e           i_order,
    input  logic [WIDTH-1:0] i_cur,
    output logic             o_dout
);

    localparam int IW = int_width(WIDTH);
    // Two guard bits so v2 + v1 - y never wraps before saturation.
    localparam int SW = IW + 2;

    localparam logic signed [SW-1:0] C_MID      = SW'(midscale(WIDTH));
    localparam logic signed [SW-1:0] C_CLAMP_HI = SW'(clamp_bound(WIDTH));
    localparam logic signed [SW-1:0] C_CLAMP_LO = SW'(-clamp_bound(WIDTH));
    localparam logic signed [SW-1:0] C_SAT_HI   = SW'((1 << (IW - 1)) - 1);
    localparam logic signed [SW-1:0] C_SAT_LO   = SW'(-(1 << (IW - 1)));

    // The 1st-order accumulator keeps only the low WIDTH bits; its carry
    // is the output bit and lives in r_dout.
    logic [WIDTH-1:0]     r_acc;
    logic signed [IW-1:0] r_v1;
    logic signed [IW-1:0] r_v2;
    logic                 r_dout;

    logic [WIDTH:0]       w_acc_sum;
    logic signed [SW-1:0] w_x_raw;
    logic signed [SW-1:0] w_x;
    logic signed [SW-1:0] w_y;
    logic signed [SW-1:0] w_v1_sum;
    logic signed [SW-1:0] w_v2_sum;
    logic signed [IW-1:0] w_v1_next;
    logic signed [IW-1:0] w_v2_next;

    function automatic logic signed [IW-1:0] sat(input logic signed [SW-1:0] v);
        if (v > C_SAT_HI)      return C_SAT_HI[IW-1:0];
        else if (v < C_SAT_LO) return C_SAT_LO[IW-1:0];
        else                   return v[IW-1:0];
    endfunction

    always_comb begin
        w_acc_sum = {1'b0, r_acc} + {1'b0, i_cur};
        w_x_raw   = $signed({{(SW-WIDTH){1'b0}}, i_cur}) - C_MID;
        // NOTE: every path assigns w_x, so this if/else chain cannot infer a latch.
        if (w_x_raw > C_CLAMP_HI)      w_x = C_CLAMP_HI;
        else if (w_x_raw < C_CLAMP_LO) w_x = C_CLAMP_LO;
        else                           w_x = w_x_raw;
        w_y       = r_dout ? C_MID : -C_MID;
        w_v1_sum  = $signed({{2{r_v1[IW-1]}}, r_v1}) + w_x - w_y;
        // v2 integrates the old v1, not the freshly computed one.
        w_v2_sum  = $signed({{2{r_v2[IW-1]}}, r_v2})
                  + $signed({{2{r_v1[IW-1]}}, r_v1}) - w_y;
        w_v1_next = sat(w_v1_sum);
        w_v2_next = sat(w_v2_sum);
    end

    // NOTE: non-blocking assignments make every register sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc  <= '0;
            r_v1   <= '0;
            r_v2   <= '0;
            r_dout <= 1'b0;
        end else if (!i_en || i_clr) begin
            r_acc  <= '0;
            r_v1   <= '0;
            r_v2   <= '0;
            r_dout <= 1'b0;
        end else if (i_order == ORDER_1) begin
            r_acc  <= w_acc_sum[WIDTH-1:0];
            r_dout <= w_acc_sum[WIDTH];
        end else begin
            r_v1   <= w_v1_next;
            r_v2   <= w_v2_next;
            r_dout <= ~w_v2_next[IW-1];
        end
    end

    assign o_dout = r_dout;

endmodule

// File: rtl/sdm_dac_mc.sv
// sdm_dac_mc: multi-channel sigma-delta audio DAC with a one-frame input buffer.
//   clk, rst_n    clock (modulator rate) and asynchronous active-low reset
//   en            modulator enable
//   order2        0 = 1st order, 1 = 2nd order; taken at frame boundaries
//   s_valid       input frame valid
//   s_ready       pending buffer empty
//   s_data        frame, channel k at [k*WIDTH +: WIDTH], offset binary
//   underrun_clr  clears the underrun flag
//   dout          registered PDM outputs, one per channel
//   frame_strobe  one-cycle pulse after each frame load
//   underrun      sticky: a boundary found no pending frame
module sdm_dac_mc
    import sdm_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 2,
    parameter int OSR_LOG2 = 10
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic                      order2,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [CHANNELS*WIDTH-1:0] s_data,
    input  logic                      underrun_clr,
    output logic [CHANNELS-1:0]       dout,
    output logic                      frame_strobe,
    output logic                      underrun
);

    logic [OSR_LOG2-1:0]       r_cnt;
    logic                      r_pend_full;
    logic [CHANNELS*WIDTH-1:0] r_pend;
    logic [CHANNELS*WIDTH-1:0] r_cur;
    order_e                    r_order_q;
    logic                      r_frame_strobe;
    logic                      r_underrun;

    order_e                    w_order_in;
    logic                      w_boundary;
    logic                      w_xfer;
    logic                      w_order_chg;
    logic [CHANNELS-1:0]       w_dout;

    assign w_order_in  = order_e'(order2);
    assign w_boundary  = en && (r_cnt == {OSR_LOG2{1'b1}});
    assign w_xfer      = s_valid && !r_pend_full;
    assign w_order_chg = w_boundary && (w_order_in != r_order_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   r_cnt <= '0;
        else if (!en) r_cnt <= '0;
        else          r_cnt <= r_cnt + OSR_LOG2'(1);
    end

    // NOTE: the sample buffers are plain registers, so they take the reset like all other state.
    // A boundary with a full buffer empties it; s_ready is low then, so a
    // transfer can never collide with the copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pend_full <= 1'b0;
            r_pend      <= '0;
            r_cur       <= '0;
        end else if (w_boundary && r_pend_full) begin
            r_cur       <= r_pend;
            r_pend_full <= 1'b0;
        end else if (w_xfer) begin
            r_pend      <= s_data;
            r_pend_full <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_strobe <= 1'b0;
            r_underrun     <= 1'b0;
            r_order_q      <= ORDER_1;
        end else begin
            r_frame_strobe <= w_boundary && r_pend_full;
            // Setting wins over a same-cycle clear.
            if (w_boundary && !r_pend_full) r_underrun <= 1'b1;
            else if (underrun_clr)          r_underrun <= 1'b0;
            if (w_boundary) r_order_q <= w_order_in;
        end
    end

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        sdm_channel #(
            .WIDTH (WIDTH)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_en    (en),
            .i_clr   (w_order_chg),
            .i_order (r_order_q),
            .i_cur   (r_cur[k*WIDTH +: WIDTH]),
            .o_dout  (w_dout[k])
        );
    end

    assign s_ready      = !r_pend_full;
    assign dout         = w_dout;
    assign frame_strobe = r_frame_strobe;
    assign underrun     = r_underrun;

endmodule

// File: tb/tb_sdm_dac_mc.sv
// tb_sdm_dac_mc: directed bench for sdm_dac_mc (WIDTH 16, 2 channels, 1024-cycle frames).
// Inputs change and outputs are sampled 1 time unit after each rising edge;
// cyc counts rising edges since the first reset release, so boundaries fall
// on multiples of 1024 while en stays high.
module tb_sdm_dac_mc;

    localparam int WIDTH    = 16;
    localparam int CHANNELS = 2;
    localparam int OSR_LOG2 = 10;
    localparam int FRAME    = 1 << OSR_LOG2;

    logic                      clk = 1'b0;
    logic                      rst_n = 1'b0;
    logic                      en = 1'b0;
    logic                      order2 = 1'b0;
    logic                      s_valid = 1'b0;
    logic                      s_ready;
    logic [CHANNELS*WIDTH-1:0] s_data = '0;
    logic                      underrun_clr = 1'b0;
    logic [CHANNELS-1:0]       dout;
    logic                      frame_strobe;
    logic                      underrun;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    sdm_dac_mc #(
        .WIDTH    (WIDTH),
        .CHANNELS (CHANNELS),
        .OSR_LOG2 (OSR_LOG2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .en           (en),
        .order2       (order2),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .underrun_clr (underrun_clr),
        .dout         (dout),
        .frame_strobe (frame_strobe),
        .underrun     (underrun)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step();
    endtask

    task automatic count_window(input int n, output int c0, output int c1);
        c0 = 0;
        c1 = 0;
        for (int i = 0; i < n; i++) begin
            step();
            c0 += int'(dout[0]);
            c1 += int'(dout[1]);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++; if (s_ready !== 1'b1) $display("FAIL reset_s_ready: got %b want 1", s_ready); else n_pass++;
        n_checks++; if (dout !== 2'b00) $display("FAIL reset_dout: got %b want 00", dout); else n_pass++;
        n_checks++; if (frame_strobe !== 1'b0) $display("FAIL reset_strobe: got %b want 0", frame_strobe); else n_pass++;
        n_checks++; if (underrun !== 1'b0) $display("FAIL reset_underrun: got %b want 0", underrun); else n_pass++;
    endtask

    // ch0 = 0x4000 (density 1/4, period 4), ch1 = 0xC000 (density 3/4).
    task automatic test_first_order();
        int o0, o1, bad;
        s_data  = {16'hC000, 16'h4000};
        s_valid = 1'b1;
        rst_n   = 1'b1;
        cyc     = 0;
        step();
        n_checks++; if (s_ready !== 1'b0) $display("FAIL fo_accept: s_ready %b want 0", s_ready); else n_pass++;
        s_valid = 1'b0;
        while (frame_strobe !== 1'b1 && cyc < FRAME + 64) step();
        n_checks++; if (cyc != FRAME) $display("FAIL fo_first_strobe: at cycle %0d want %0d", cyc, FRAME); else n_pass++;
        o0 = 0; o1 = 0; bad = 0;
        for (int k = 1; k <= FRAME; k++) begin
            step();
            o0 += int'(dout[0]);
            o1 += int'(dout[1]);
            if (dout[0] !== (k % 4 == 0)) bad++;
        end
        n_checks++; if (o0 != 256) $display("FAIL fo_ones_ch0: got %0d want 256", o0); else n_pass++;
        n_checks++; if (o1 != 768) $display("FAIL fo_ones_ch1: got %0d want 768", o1); else n_pass++;
        n_checks++; if (bad != 0) $display("FAIL fo_period_ch0: %0d misplaced bits want 0", bad); else n_pass++;
    endtask

    // Boundary at 2048 finds no pending frame.
    task automatic test_underrun();
        int o0, o1;
        n_checks++; if (underrun !== 1'b1) $display("FAIL ur_set: got %b want 1", underrun); else n_pass++;
        n_checks++; if (frame_strobe !== 1'b0) $display("FAIL ur_no_strobe: got %b want 0", frame_strobe); else n_pass++;
        count_window(FRAME, o0, o1);
        n_checks++; if (o0 != 256) $display("FAIL ur_held_ch0: got %0d want 256", o0); else n_pass++;
        n_checks++; if (o1 != 768) $display("FAIL ur_held_ch1: got %0d want 768", o1); else n_pass++;
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        n_checks++; if (underrun !== 1'b0) $display("FAIL ur_clear: got %b want 0", underrun); else n_pass++;
    endtask

    // A = {0x2000, 0x8000}, B = {0x4000, 0xC000}; both accumulators are 0 when A loads.
    task automatic test_back_to_back();
        int a0, a1, c0, c1, stall;
        s_data  = {16'h2000, 16'h8000};
        s_valid = 1'b1;
        step();
        n_checks++; if (s_ready !== 1'b0) $display("FAIL bp_a_accept: s_ready %b want 0", s_ready); else n_pass++;
        s_data = {16'h4000, 16'hC000};
        stall  = 0;
        while (cyc < 2 * FRAME * 2 - 1) begin
            step();
            if (s_ready !== 1'b0) stall++;
        end
        n_checks++; if (stall != 0) $display("FAIL bp_stall: s_ready high %0d times want 0", stall); else n_pass++;
        step();
        n_checks++; if (frame_strobe !== 1'b1) $display("FAIL bp_a_strobe: got %b want 1", frame_strobe); else n_pass++;
        n_checks++; if (s_ready !== 1'b1) $display("FAIL bp_ready_boundary: got %b want 1", s_ready); else n_pass++;
        n_checks++; if (underrun !== 1'b0) $display("FAIL bp_no_underrun: got %b want 0", underrun); else n_pass++;
        step();
        n_checks++; if (s_ready !== 1'b0) $display("FAIL bp_b_accept: s_ready %b want 0", s_ready); else n_pass++;
        s_valid = 1'b0;
        a0 = int'(dout[0]);
        a1 = int'(dout[1]);
        count_window(FRAME - 1, c0, c1);
        a0 += c0;
        a1 += c1;
        n_checks++; if (a0 != 512) $display("FAIL bp_a_ch0: got %0d want 512", a0); else n_pass++;
        n_checks++; if (a1 != 128) $display("FAIL bp_a_ch1: got %0d want 128", a1); else n_pass++;
        n_checks++; if (frame_strobe !== 1'b1) $display("FAIL bp_b_strobe: got %b want 1", frame_strobe); else n_pass++;
        count_window(FRAME - 1, c0, c1);
        n_checks++; if (c0 != 767) $display("FAIL bp_b_ch0: got %0d want 767", c0); else n_pass++;
        n_checks++; if (c1 != 255) $display("FAIL bp_b_ch1: got %0d want 255", c1); else n_pass++;
        // Boundary at 6144 sets underrun while clear is also asserted.
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        n_checks++; if (underrun !== 1'b1) $display("FAIL ur_set_priority: got %b want 1", underrun); else n_pass++;
    endtask

    // B stays 1st order (ch0 0xC000 pattern 0111) until the boundary at 7168.
    task automatic test_order_switch();
        int bad;
        s_data  = {16'h8000, 16'h8000};
        s_valid = 1'b1;
        bad     = 0;
        for (int k = 1; k < FRAME; k++) begin
            step();
            if (k == 1) s_valid = 1'b0;
            if (k == 356) order2 = 1'b1;
            if (dout[0] !== (k % 4 != 1)) bad++;
        end
        n_checks++; if (bad != 0) $display("FAIL os_still_first: %0d wrong bits want 0", bad); else n_pass++;
        n_checks++; if (s_ready !== 1'b0) $display("FAIL os_pending: s_ready %b want 0", s_ready); else n_pass++;
        step();
        n_checks++; if (frame_strobe !== 1'b1) $display("FAIL os_strobe: got %b want 1", frame_strobe); else n_pass++;
        n_checks++; if (dout !== 2'b00) $display("FAIL os_clear: dout %b want 00", dout); else n_pass++;
    endtask

    // Midscale settles to half density; 0x9000 (x = +4096) to 9/16.
    task automatic test_second_order();
        int c0, c1;
        run_to(8 * FRAME);
        s_data  = {16'h9000, 16'h9000};
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        c0 = int'(dout[0]);
        c1 = int'(dout[1]);
        begin
            int d0, d1;
            count_window(FRAME - 1, d0, d1);
            c0 += d0;
            c1 += d1;
        end
        n_checks++; if (c0 < 510 || c0 > 514) $display("FAIL so_mid_ch0: got %0d want 510..514", c0); else n_pass++;
        n_checks++; if (c1 < 510 || c1 > 514) $display("FAIL so_mid_ch1: got %0d want 510..514", c1); else n_pass++;
        run_to(10 * FRAME);
        count_window(FRAME, c0, c1);
        n_checks++; if (c0 < 572 || c0 > 580) $display("FAIL so_9000_ch0: got %0d want 572..580", c0); else n_pass++;
        n_checks++; if (c1 < 572 || c1 > 580) $display("FAIL so_9000_ch1: got %0d want 572..580", c1); else n_pass++;
    endtask

    task automatic test_enable();
        int n;
        en = 1'b0;
        step();
        n_checks++; if (dout !== 2'b00) $display("FAIL en_off_dout: got %b want 00", dout); else n_pass++;
        s_data  = {16'h4000, 16'h8000};
        s_valid = 1'b1;
        step();
        n_checks++; if (s_ready !== 1'b0) $display("FAIL en_off_accept: s_ready %b want 0", s_ready); else n_pass++;
        s_valid = 1'b0;
        step();
        en = 1'b1;
        n  = 0;
        while (frame_strobe !== 1'b1 && n < FRAME + 64) begin
            step();
            n++;
        end
        n_checks++; if (n != FRAME) $display("FAIL en_first_boundary: after %0d cycles want %0d", n, FRAME); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int n;
        s_data  = {16'h1234, 16'h5678};
        s_valid = 1'b1;
        step();
        s_valid = 1'b0;
        repeat (37) step();
        n_checks++; if (underrun !== 1'b1) $display("FAIL rm_pre_underrun: got %b want 1", underrun); else n_pass++;
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++; if (dout !== 2'b00) $display("FAIL rm_dout: got %b want 00", dout); else n_pass++;
        n_checks++; if (underrun !== 1'b0) $display("FAIL rm_underrun: got %b want 0", underrun); else n_pass++;
        n_checks++; if (frame_strobe !== 1'b0) $display("FAIL rm_strobe: got %b want 0", frame_strobe); else n_pass++;
        n_checks++; if (s_ready !== 1'b1) $display("FAIL rm_s_ready: got %b want 1", s_ready); else n_pass++;
        @(posedge clk);
        #1;
        s_valid = 1'b1;
        rst_n   = 1'b1;
        n       = 0;
        while (frame_strobe !== 1'b1 && n < FRAME + 64) begin
            step();
            n++;
            s_valid = 1'b0;
        end
        n_checks++; if (n != FRAME) $display("FAIL rm_restart: strobe after %0d cycles want %0d", n, FRAME); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_first_order();
        test_underrun();
        test_back_to_back();
        test_order_switch();
        test_second_order();
        test_enable();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
